// File: rtl/iir_sos_tdm.sv
// Purpose : cascade of NSEC biquad sections, time-multiplexed onto one signed multiplier.
// Latency : out_valid rises 5*NSEC+1 cycles after a sample is accepted; one sample per 5*NSEC+2 cycles.
// Backpressure: in_ready is high only while idle; the sample must be held until in_valid && in_ready.
//
// Ports:
//   clk, rst (async, active-low)    clock and reset
//   clear                           synchronous flush of delay states, aborts a running sample
//   in_valid / in_ready / x         input sample handshake
//   out_valid / y / ovf             one-cycle result pulse; y held between pulses, ovf = saturation seen
//   coef_we / coef_addr / coef_wdata coefficient write port, index = section*5 + {b0,b1,b2,a1,a2}
//   coef_err                        one-cycle pulse when a write was dropped
module iir_sos_tdm #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 32,
  parameter int FRAC   = 20,
  parameter int NSEC   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  output logic              out_valid,
  output logic [DATA_W-1:0] y,
  output logic              ovf,
  input  logic              coef_we,
  input  logic [7:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              coef_err
);

  localparam int NCOEF = 5 * NSEC;
  localparam int IDX_W = $clog2(NCOEF);
  localparam int SEC_W = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + 4;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                    state_q, state_d;
  logic [SEC_W-1:0]          sec_q;
  logic [2:0]                k_q;
  logic [IDX_W-1:0]          cidx_q;
  logic signed [COEF_W-1:0]  coef_q [NCOEF];
  logic signed [DATA_W-1:0]  z1b_q [NSEC];
  logic signed [DATA_W-1:0]  z2b_q [NSEC];
  logic signed [DATA_W-1:0]  z1a_q [NSEC];
  logic signed [DATA_W-1:0]  z2a_q [NSEC];
  logic signed [DATA_W-1:0]  w_q;
  logic [DATA_W-1:0]         y_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      flag_q, out_valid_q, ovf_q, coef_err_q;

  logic                      accept, coef_ok, sec_end, last_sec, sat_hi, sat_lo;
  logic signed [DATA_W-1:0]  data_op, r;
  logic signed [COEF_W-1:0]  coef_op;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext, acc_sum, rnd;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = CALC;
        CALC:    if (sec_end && last_sec) state_d = OUT;
        OUT:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs / qualifiers ----------------
  always_comb begin
    // rst gates in_ready so nothing is offered while reset is held
    in_ready = rst && (state_q == IDLE);
    accept   = in_valid && in_ready && !clear;
    coef_ok  = coef_we && (state_q == IDLE) && (coef_addr < 8'(NCOEF));
    sec_end  = (k_q == 3'd4);
    last_sec = (sec_q == SEC_W'(NSEC - 1));
  end

  // ---------------- shared MAC datapath ----------------
  always_comb begin
    case (k_q)
      3'd1:    data_op = z1b_q[sec_q];
      3'd2:    data_op = z2b_q[sec_q];
      3'd3:    data_op = z1a_q[sec_q];
      3'd4:    data_op = z2a_q[sec_q];
      default: data_op = w_q;
    endcase
    coef_op  = coef_q[cidx_q];
    prod     = PW'(data_op) * PW'(coef_op);
    prod_ext = {{4{prod[PW-1]}}, prod};
    // feed-forward terms add, feedback terms subtract
    acc_sum  = (k_q < 3'd3) ? (acc_q + prod_ext) : (acc_q - prod_ext);
    rnd      = (acc_sum + HALF) >>> FRAC;
    sat_hi   = (rnd > MAXV);
    sat_lo   = (rnd < MINV);
    if (sat_hi)      r = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sat_lo) r = {1'b1, {(DATA_W-1){1'b0}}};
    else             r = rnd[DATA_W-1:0];
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q       <= '0;
      k_q         <= '0;
      cidx_q      <= '0;
      w_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      coef_err_q  <= 1'b0;
      for (int i = 0; i < NCOEF; i++)
        coef_q[i] <= (i % 5 == 0) ? COEF_W'(1) << FRAC : '0;
      for (int s = 0; s < NSEC; s++) begin
        z1b_q[s] <= '0;
        z2b_q[s] <= '0;
        z1a_q[s] <= '0;
        z2a_q[s] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      coef_err_q  <= coef_we && !coef_ok;
      if (coef_ok) coef_q[coef_addr[IDX_W-1:0]] <= coef_wdata;

      if (clear) begin
        acc_q  <= '0;
        flag_q <= 1'b0;
        for (int s = 0; s < NSEC; s++) begin
          z1b_q[s] <= '0;
          z2b_q[s] <= '0;
          z1a_q[s] <= '0;
          z2a_q[s] <= '0;
        end
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            w_q    <= x;
            sec_q  <= '0;
            k_q    <= '0;
            cidx_q <= '0;
            acc_q  <= '0;
            flag_q <= 1'b0;
          end
          CALC: begin
            cidx_q <= cidx_q + IDX_W'(1);
            if (sec_end) begin
              // r is this section's output and the next section's input
              z2b_q[sec_q] <= z1b_q[sec_q];
              z1b_q[sec_q] <= w_q;
              z2a_q[sec_q] <= z1a_q[sec_q];
              z1a_q[sec_q] <= r;
              w_q          <= r;
              acc_q        <= '0;
              k_q          <= '0;
              sec_q        <= sec_q + SEC_W'(1);
              flag_q       <= flag_q | sat_hi | sat_lo;
            end else begin
              acc_q <= acc_sum;
              k_q   <= k_q + 3'd1;
            end
          end
          OUT: begin
            y_q         <= w_q;
            out_valid_q <= 1'b1;
            ovf_q       <= flag_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign coef_err  = coef_err_q;

endmodule

// File: doc/iir_sos_tdm.md
IIR_SOS_TDM -- requirements
Module: iir_sos_tdm

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, signed sample width of x, y and all delay-state registers.
REQ-002 SHALL provide parameter COEF_W, default 32, signed coefficient width.
REQ-003 SHALL provide parameter FRAC, default 20, number of fractional bits in every coefficient (Q-format).
REQ-004 SHALL provide parameter NSEC, default 3, number of cascaded second-order sections (1..16).
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 clear  in  1  synchronous flush of all delay states and abort of any computation.
REQ-008 in_valid  in  1  x holds a sample to accept.
REQ-009 in_ready  out  1  block can accept a sample this cycle.
REQ-010 x  in  DATA_W  signed input sample.
REQ-011 out_valid  out  1  one-cycle pulse, y updated this cycle.
REQ-012 y  out  DATA_W  signed filtered output, registered, held between pulses.
REQ-013 ovf  out  1  valid with out_valid, 1 if any section saturated on this sample.
REQ-014 coef_we  in  1  coefficient write strobe.
REQ-015 coef_addr  in  8  coefficient index = section*5 + k, k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
REQ-016 coef_wdata  in  COEF_W  signed coefficient value.
REQ-017 coef_err  out  1  one-cycle pulse, last write was dropped.

Function
REQ-018 SHALL use exactly one signed DATA_W x COEF_W multiplier, time-shared across all products.
REQ-019 FSM SHALL have states IDLE, CALC, OUT; in_ready = 1 only in IDLE.
REQ-020 IDLE: in_valid && in_ready latches x as section-0 input w and enters CALC with section=0, k=0.
REQ-021 CALC: one product per cycle, order b0*w, b1*z1b, b2*z2b, a1*z1a, a2*z2a; b products are added and a products subtracted in a signed accumulator of width DATA_W+COEF_W+4.
REQ-022 End of each section: r = (acc + 2^(FRAC-1)) >>> FRAC (round half up), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; saturation sets the per-sample ovf flag.
REQ-023 End of each section: z2b<=z1b, z1b<=w, z2a<=z1a, z1a<=r for that section only; r becomes w of the next section; accumulator cleared.
REQ-024 After section NSEC-1 the FSM SHALL enter OUT: y<=r, out_valid=1, ovf=flag for one cycle, then return to IDLE.
REQ-025 Latency: out_valid high exactly 5*NSEC+1 cycles after the accepting edge; throughput one sample per 5*NSEC+2 cycles.
REQ-026 Coefficient write in IDLE with coef_addr < 5*NSEC SHALL update the addressed register on that edge, effective for the next accepted sample.
REQ-027 Write in CALC/OUT or with coef_addr >= 5*NSEC SHALL be dropped and coef_err pulsed next cycle.
REQ-028 clear SHALL zero all z registers, the accumulator and the ovf flag and force IDLE next cycle without out_valid; y is held; clear has priority over sample acceptance in the same cycle.
REQ-029 clear with a simultaneous legal coef_we in IDLE SHALL perform both.

Reset
REQ-030 rst low: FSM=IDLE, all z registers, accumulator, y=0, out_valid=0, ovf=0, coef_err=0, in_ready=0 while asserted and 1 from the first cycle after release.
REQ-031 rst low: every section b0 = 2^FRAC, b1=b2=a1=a2 = 0 (unity passthrough).

Verification
REQ-032 Reset defaults, NSEC=3: x=1000 accepted -> y=1000, out_valid exactly 16 cycles later, ovf=0.
REQ-033 NSEC=1, coefs b0=5509, b1=11019, b2=5509, a1=-1998080, a2=971584; impulse x=1048576 then 0 -> y=5509, then y=21516.
REQ-034 NSEC=1, b0=4194304, x=0x40000000 -> y=0x7FFFFFFF, ovf=1; x=-0x40000000 -> y=-0x80000000, ovf=1.
REQ-035 clear asserted 3 cycles after accept -> no out_valid, in_ready=1 next cycle; next x=1000 with reset coefs -> y=1000.
REQ-036 coef_we during CALC or coef_addr=5*NSEC -> coef_err pulse, next sample output unchanged vs no write.
REQ-037 rst asserted mid-CALC -> out_valid never asserts, coefs return to passthrough, first post-reset sample passes unchanged.
